fifo_param: RTL and testbench
=============================

# fifo_param

Parametrised, fully synchronous successor to the cache-side request FIFO, with configurable width and depth. It has two read ports: a processor pop port and a snoop pop port with fixed priority arbitration. It also provides occupancy and threshold status, synchronous flush, and overflow/underflow error pulses. It sits between the cache controller and the bus interface, buffering outgoing requests that either the processor side or the snoop handler may drain.

## Interface
Parameters:
- DATA_W, 4, entry width in bits
- DEPTH, 16, number of entries; must be a power of two, ≥ 2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH

Ports:
- Reset is asynchronous and active-low (rst_n). All logic is clocked on the rising edge of clk.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  push request
- wr_data  in  DATA_W  push data
- rd_en  in  1  processor pop request
- rd_data  out  DATA_W  processor pop data, registered
- rd_valid  out  1  rd_data updated this cycle
- rd_blocked  out  1  processor pop lost arbitration to snoop
- rd_en_snoop  in  1  snoop pop request
- snoop_data  out  DATA_W  snoop pop data, registered
- snoop_valid  out  1  snoop_data updated this cycle
- flush  in  1  synchronous clear of contents
- buf_empty  out  1  count == 0
- buf_full  out  1  count == DEPTH
- almost_empty  out  1  count ≤ AE_THRESH
- almost_full  out  1  count ≥ AF_THRESH
- fifo_count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  one-cycle pulse, write dropped
- underflow  out  1  one-cycle pulse, pop dropped

## Operation
- Storage is DEPTH × DATA_W. Pointers are wr_ptr/rd_ptr, each $clog2(DEPTH) bits, and wrap naturally modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Pop arbitration. At most one pop is accepted per cycle, and snoop has priority.
  - rd_en_snoop & !empty: snoop pop accepted; head goes to snoop_data; snoop_valid pulses.
  - rd_en & rd_en_snoop & !empty: processor pop not accepted; rd_blocked pulses; rd_data holds.
  - rd_en & !rd_en_snoop & !empty: processor pop accepted; head goes to rd_data; rd_valid pulses.
- Push accepted when wr_en & (!full | pop accepted this cycle). Data is written at wr_ptr and wr_ptr increments.
- Count update: +1 on push only, −1 on pop only, unchanged on push+pop or neither.
- Empty + push + pop: the pop is rejected (no bypass) and the push is accepted. Underflow pulses and count goes to 1.
- Full + push + accepted pop: both proceed, count stays DEPTH, pointers advance.
- Overflow: wr_en & full & no accepted pop. Data is dropped, state is unchanged, overflow pulses.
- Underflow: any pop request (rd_en or rd_en_snoop) while empty. The request is dropped and underflow pulses. rd_blocked never asserts when empty.
- Flush has priority over push and pop in the same cycle.
  - Pointers and count go to 0.
  - rd_data/snoop_data hold.
  - No valid, error or blocked pulses are generated.
- Stored contents are not cleared by reset or flush; they are don't-care once pointers reset.

## Timing
- Outputs registered on clk rising edge. Status outputs decode from registered count, so they reflect state after the previous edge.
- Pop latency:
  - Request sampled at edge N.
  - rd_data/snoop_data and the matching valid are valid after edge N, for exactly one cycle of valid.
  - Data holds afterward.
- Push visible: count/empty update after the accepting edge. A pushed entry can be popped at the next edge at the earliest.
- overflow, underflow, rd_blocked, rd_valid, snoop_valid are single-cycle pulses per offending/accepted edge; back-to-back events give back-to-back pulses.
- Reset values, applied asynchronously on rst_n low and held until release:
  - Pointers and count: 0.
  - rd_data, snoop_data: 0.
  - All pulses: 0.
  - buf_full, almost_full: 0.
  - buf_empty, almost_empty: 1.
- Reset mid-operation aborts any in-flight pop; the first edge after rst_n rises behaves as an empty FIFO.
- Sustained throughput is one push and one pop per cycle.

## Test plan
- Reset, then push 0x1..0x5, then rd_en ×5: rd_data reads 1,2,3,4,5 on consecutive cycles with rd_valid high each. fifo_count goes 5→0; buf_empty rises after the last pop.
- Fill 16 entries with DATA_W=4, DEPTH=16:
  - buf_full=1, almost_full has been 1 since count=14.
  - One more wr_en: overflow pulse, count stays 16.
  - Then wr_en+rd_en together: both accepted, rd_data=first entry, count=16.
- With 3 entries queued (A,B,C), assert rd_en and rd_en_snoop together: snoop_data=A with snoop_valid, rd_blocked=1, rd_valid=0, count=2. A following rd_en alone returns B.
- Empty FIFO, wr_en+rd_en with data 0x9: underflow pulses, count=1, rd_valid=0. The next rd_en returns 0x9.
- Push 8 entries, then flush together with wr_en and rd_en: count=0, buf_empty=1, no pulses, rd_data unchanged. Wrap test: push/pop 40 entries streaming and check order across pointer wrap.
- Push 6 entries, assert rst_n low mid-cycle: all outputs reach reset values immediately. After release, rd_en gives underflow, not stale data.

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised request FIFO with a processor pop port and a higher-priority snoop pop port.
// Provides occupancy/threshold status, synchronous flush, and overflow/underflow pulses.
module fifo_param #(
  parameter int DATA_W    = 4,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     rd_blocked,
  input  logic                     rd_en_snoop,
  output logic [DATA_W-1:0]        snoop_data,
  output logic                     snoop_valid,
  input  logic                     flush,
  output logic                     buf_empty,
  output logic                     buf_full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] snoop_data_q, snoop_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              snoop_valid_q, snoop_valid_d;
  logic              rd_blocked_q, rd_blocked_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              empty;
  logic              full;
  logic              snoop_pop;
  logic              proc_pop;
  logic              pop_acc;
  logic              push;
  logic [DATA_W-1:0] head;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign head  = mem[rd_ptr_q];

  // Flush masks every request, so it also suppresses all pulses that cycle.
  assign snoop_pop = rd_en_snoop && !empty && !flush;
  assign proc_pop  = rd_en && !rd_en_snoop && !empty && !flush;
  assign pop_acc   = snoop_pop || proc_pop;
  assign push      = wr_en && (!full || pop_acc) && !flush;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    rd_data_d     = rd_data_q;
    snoop_data_d  = snoop_data_q;
    rd_valid_d    = proc_pop;
    snoop_valid_d = snoop_pop;
    rd_blocked_d  = rd_en && rd_en_snoop && !empty && !flush;
    overflow_d    = wr_en && full && !pop_acc && !flush;
    underflow_d   = (rd_en || rd_en_snoop) && empty && !flush;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop_acc) begin
        count_d = count_q + CW'(1);
      end else if (pop_acc && !push) begin
        count_d = count_q - CW'(1);
      end
      if (proc_pop) begin
        rd_data_d = head;
      end
      if (snoop_pop) begin
        snoop_data_d = head;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rd_data_q     <= '0;
      snoop_data_q  <= '0;
      rd_valid_q    <= 1'b0;
      snoop_valid_q <= 1'b0;
      rd_blocked_q  <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rd_data_q     <= rd_data_d;
      snoop_data_q  <= snoop_data_d;
      rd_valid_q    <= rd_valid_d;
      snoop_valid_q <= snoop_valid_d;
      rd_blocked_q  <= rd_blocked_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign rd_blocked   = rd_blocked_q;
  assign snoop_data   = snoop_data_q;
  assign snoop_valid  = snoop_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign fifo_count   = count_q;
  assign buf_empty    = empty;
  assign buf_full     = full;
  assign almost_empty = (count_q <= AE_C);
  assign almost_full  = (count_q >= AF_C);

endmodule

// File: tb/tb_fifo_param.sv
// Directed and randomized bench for fifo_param, checked against a queue-based reference model.
module tb_fifo_param;

  localparam int DATA_W    = 4;
  localparam int DEPTH     = 16;
  localparam int AF_THRESH = DEPTH - 2;
  localparam int AE_THRESH = 2;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_blocked;
  logic              rd_en_snoop;
  logic [DATA_W-1:0] snoop_data;
  logic              snoop_valid;
  logic              flush;
  logic              buf_empty;
  logic              buf_full;
  logic              almost_empty;
  logic              almost_full;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              overflow;
  logic              underflow;

  int nAsserts = 0;
  int nFail    = 0;

  logic [DATA_W-1:0] modelQ[$];
  logic [DATA_W-1:0] expRdData;
  logic [DATA_W-1:0] expSnoopData;
  logic expRdValid, expSnoopValid, expBlocked, expOverflow, expUnderflow;

  fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_blocked(rd_blocked),
    .rd_en_snoop(rd_en_snoop), .snoop_data(snoop_data), .snoop_valid(snoop_valid),
    .flush(flush),
    .buf_empty(buf_empty), .buf_full(buf_full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic checkOutput(input string tag);
    int sz;
    sz = modelQ.size();
    checkVal({tag, ".rd_data"},      32'(rd_data),      32'(expRdData));
    checkVal({tag, ".rd_valid"},     32'(rd_valid),     32'(expRdValid));
    checkVal({tag, ".rd_blocked"},   32'(rd_blocked),   32'(expBlocked));
    checkVal({tag, ".snoop_data"},   32'(snoop_data),   32'(expSnoopData));
    checkVal({tag, ".snoop_valid"},  32'(snoop_valid),  32'(expSnoopValid));
    checkVal({tag, ".overflow"},     32'(overflow),     32'(expOverflow));
    checkVal({tag, ".underflow"},    32'(underflow),    32'(expUnderflow));
    checkVal({tag, ".fifo_count"},   32'(fifo_count),   32'(sz));
    checkVal({tag, ".buf_empty"},    32'(buf_empty),    32'(sz == 0));
    checkVal({tag, ".buf_full"},     32'(buf_full),     32'(sz == DEPTH));
    checkVal({tag, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE_THRESH));
    checkVal({tag, ".almost_full"},  32'(almost_full),  32'(sz >= AF_THRESH));
  endtask

  task automatic modelReset();
    modelQ.delete();
    expRdData     = '0;
    expSnoopData  = '0;
    expRdValid    = 1'b0;
    expSnoopValid = 1'b0;
    expBlocked    = 1'b0;
    expOverflow   = 1'b0;
    expUnderflow  = 1'b0;
  endtask

  // One clock of stimulus: predict the outcome from the queue, clock it in, compare.
  task automatic applyStimulus(input string tag, input logic w, input logic [DATA_W-1:0] d,
                               input logic r, input logic s, input logic f);
    int  sizeBefore;
    logic popped;
    wr_en = w; wr_data = d; rd_en = r; rd_en_snoop = s; flush = f;
    expRdValid = 1'b0; expSnoopValid = 1'b0; expBlocked = 1'b0;
    expOverflow = 1'b0; expUnderflow = 1'b0;
    sizeBefore = modelQ.size();
    popped = 1'b0;
    if (f) begin
      modelQ.delete();
    end else begin
      if ((r || s) && sizeBefore == 0) expUnderflow = 1'b1;
      if (sizeBefore != 0) begin
        if (s) begin
          expSnoopData = modelQ.pop_front();
          expSnoopValid = 1'b1;
          popped = 1'b1;
          if (r) expBlocked = 1'b1;
        end else if (r) begin
          expRdData = modelQ.pop_front();
          expRdValid = 1'b1;
          popped = 1'b1;
        end
      end
      if (w) begin
        if (sizeBefore < DEPTH || popped) modelQ.push_back(d);
        else expOverflow = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rd_en_snoop = 1'b0; flush = 1'b0;
    modelReset();
    #3;
    checkOutput("reset");
    #9;
    rst_n = 1'b1;

    for (int i = 1; i <= 5; i++) applyStimulus("push5", 1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  applyStimulus("pop5", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b1, DATA_W'(i + 3), 1'b0, 1'b0, 1'b0);
    applyStimulus("overflow", 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    applyStimulus("fullPushPop", 1'b1, 4'hB, 1'b1, 1'b0, 1'b0);
    applyStimulus("flush1", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    applyStimulus("pushA", 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    applyStimulus("pushB", 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    applyStimulus("pushC", 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    applyStimulus("arbitrate", 1'b0, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus("popAfterArb", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("flush2", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    applyStimulus("emptyPushPop", 1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    applyStimulus("popNine", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("snoopEmpty", 1'b0, '0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) applyStimulus("push8", 1'b1, DATA_W'(i + 1), 1'b0, 1'b0, 1'b0);
    applyStimulus("flushAll", 1'b1, 4'h7, 1'b1, 1'b1, 1'b1);

    applyStimulus("streamFirst", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 40; i++) applyStimulus("stream", 1'b1, DATA_W'(i), 1'b1, 1'b0, 1'b0);
    applyStimulus("streamLast", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("random",
                    $urandom_range(0, 99) < 55,
                    DATA_W'($urandom),
                    $urandom_range(0, 99) < 40,
                    $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 3);
    end

    applyStimulus("preResetFlush", 1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus("push6", 1'b1, DATA_W'(i + 5), 1'b0, 1'b0, 1'b0);
    wr_en = 1'b0; rd_en = 1'b0; rd_en_snoop = 1'b0; flush = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midReset");
    @(negedge clk);
    checkOutput("heldReset");
    rst_n = 1'b1;
    applyStimulus("popAfterReset", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus("idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
